// File: rtl/philv_core_arbiter_pkg.sv
// Shared constants for the philosophy_v core arbiter slice: default widths,
// requester IDs, R-type opcode fields understood by the core, and the
// two-way round-robin pick function.
package philv_core_arbiter_pkg;

   localparam int PHILV_N           = 32;
   localparam int PHILV_INSTR_WIDTH = 32;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam logic [6:0] OPC_OP  = 7'h33;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // A lone requester always wins; under contention the one not served last wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
      logic [1:0] g;
      case (valid)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/philosophy_v_core.sv
// Combinational philosophy_v execution core: decodes an R-type instruction
// and produces c from operands a and b. Unknown encodings yield zero.
module philosophy_v_core
   import philv_core_arbiter_pkg::*;
#(
   parameter int N           = PHILV_N,
   parameter int INSTR_WIDTH = PHILV_INSTR_WIDTH
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [N-1:0]           a,
   input  logic [N-1:0]           b,
   output logic [N-1:0]           c
);

   localparam int SHW = $clog2(N);

   logic [6:0]     opcode;
   logic [2:0]     funct3;
   logic [6:0]     funct7;
   logic           alt;
   logic [SHW-1:0] shamt;
   logic           unused_instr_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign alt    = (funct7 == F7_ALT);
   assign shamt  = b[SHW-1:0];

   // Register-field bits are meaningless to a core fed directly with operands.
   assign unused_instr_fields = ^instr[24:15] ^ ^instr[11:7];

   // Operation select and evaluation.
   always_comb begin
      c = '0;
      if (opcode == OPC_OP && (funct7 == F7_BASE || funct7 == F7_ALT)) begin
         case (funct3)
            F3_ADD:  c = alt ? (a - b) : (a + b);
            F3_SLL:  c = a << shamt;
            F3_SLT:  c = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: c = {{(N-1){1'b0}}, (a < b)};
            F3_XOR:  c = a ^ b;
            F3_SR:   c = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   c = a | b;
            F3_AND:  c = a & b;
            default: c = '0;
         endcase
      end
   end

endmodule

// File: rtl/philv_core_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. Holds the last-served pointer, which
// moves only when the granted request is actually accepted.
module philv_rr_arb2
   import philv_core_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic       can_accept,
   output logic [1:0] grant
);

   logic last_grant_q;
   logic last_grant_d;
   logic accept;

   // Grant is a pure function of who is asking and who was served last.
   always_comb begin
      grant = rr_pick(req_valid, last_grant_q);
   end

   // Pointer follows accepts only; a grant stalled by backpressure leaves it alone.
   always_comb begin
      accept       = can_accept & (|(req_valid & grant));
      last_grant_d = accept ? grant[1] : last_grant_q;
   end

   // Reset to REQ1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= REQ1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/philv_core_arbiter.sv
// Shares one combinational philosophy_v_core between two requesters with
// round-robin arbitration. The result lands in a single output slot tagged
// with the winning requester; per-requester issue counters wrap silently.
module philv_core_arbiter
   import philv_core_arbiter_pkg::*;
#(
   parameter int N           = PHILV_N,
   parameter int INSTR_WIDTH = PHILV_INSTR_WIDTH,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [INSTR_WIDTH-1:0] req0_instr,
   input  logic [N-1:0]           req0_a,
   input  logic [N-1:0]           req0_b,
   input  logic [INSTR_WIDTH-1:0] req1_instr,
   input  logic [N-1:0]           req1_a,
   input  logic [N-1:0]           req1_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [N-1:0]           rsp_c,
   output logic [CNT_WIDTH-1:0]   issued0,
   output logic [CNT_WIDTH-1:0]   issued1
);

   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_id_q,    rsp_id_d;
   logic [N-1:0]           rsp_c_q,     rsp_c_d;
   logic [CNT_WIDTH-1:0]   issued0_q,   issued0_d;
   logic [CNT_WIDTH-1:0]   issued1_q,   issued1_d;

   logic                   can_accept;
   logic [1:0]             grant;
   logic                   accept;
   logic                   sel;
   logic [INSTR_WIDTH-1:0] core_instr;
   logic [N-1:0]           core_a;
   logic [N-1:0]           core_b;
   logic [N-1:0]           core_c;

   philv_rr_arb2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .can_accept (can_accept),
      .grant      (grant)
   );

   philosophy_v_core #(
      .N           (N),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_core (
      .instr (core_instr),
      .a     (core_a),
      .b     (core_b),
      .c     (core_c)
   );

   // Slot is free when empty or when its current occupant leaves this cycle.
   always_comb begin
      can_accept = ~rsp_valid_q | rsp_ready;
      req_ready  = grant & {2{can_accept}};
      accept     = |(req_valid & req_ready);
      sel        = req_ready[1];
   end

   // Operand mux feeding the shared core from the granted port.
   always_comb begin
      core_instr = sel ? req1_instr : req0_instr;
      core_a     = sel ? req1_a     : req0_a;
      core_b     = sel ? req1_b     : req0_b;
   end

   // Next-state for the output slot and the issue counters.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_c_d     = rsp_c_q;
      issued0_d   = issued0_q;
      issued1_d   = issued1_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = sel ? REQ1 : REQ0;
         rsp_c_d     = core_c;
         if (sel) begin
            issued1_d = issued1_q + 1'b1;
         end else begin
            issued0_d = issued0_q + 1'b1;
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Output slot and counters; reset discards any held response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= REQ0;
         rsp_c_q     <= '0;
         issued0_q   <= '0;
         issued1_q   <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_c_q     <= rsp_c_d;
         issued0_q   <= issued0_d;
         issued1_q   <= issued1_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_c     = rsp_c_q;
   assign issued0   = issued0_q;
   assign issued1   = issued1_q;

endmodule
